// File: rtl/param_alu_top.sv
// Push-button ALU: debounced load/execute buttons, 2*WIDTH-bit result, multiplexed hex display.
// Single-cycle ops settle one edge after the press; MUL/DIV take WIDTH extra clocks; presses outside IDLE are dropped.
module param_alu_top #(
    parameter int WIDTH        = 8,
    parameter int DIGITS       = 4,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int REFRESH_DIV  = 50000
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               pb_a,
    input  logic               pb_b,
    input  logic               pb_op,
    input  logic [WIDTH-1:0]   sw,
    output logic [WIDTH-1:0]   LED,
    output logic [DIGITS-1:0]  AN_SEL,
    output logic [6:0]         seven_seg_out,
    output logic               busy,
    output logic               result_valid,
    output logic [4:0]         flags
);

    localparam int RW  = 2 * WIDTH;
    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RFW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STW = $clog2(WIDTH);

    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_CYC);
    localparam logic [RFW-1:0] RF_LAST = RFW'(REFRESH_DIV - 1);
    localparam logic [DGW-1:0] DG_LAST = DGW'(DIGITS - 1);
    localparam logic [STW-1:0] ST_LAST = STW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                           OP_MUL = 4'd8, OP_DIV = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // Button conditioning: index 0 = pb_a, 1 = pb_b, 2 = pb_op
    logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d, prev_q, prev_d, press;
    logic [DBW-1:0] dbc_q [3];
    logic [DBW-1:0] dbc_d [3];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, led_q, led_d, work_c_q, work_c_d;
    logic [RW-1:0]    result_q, result_d, work_a_q, work_a_d, work_b_q, work_b_d;
    logic [4:0]       flags_q, flags_d;
    logic [3:0]       op_q, op_d;
    logic [STW-1:0]   step_q, step_d;
    logic [RFW-1:0]   rf_cnt_q, rf_cnt_d;
    logic [DGW-1:0]   digit_q, digit_d;

    always_comb begin
        sync1_d = {pb_op, pb_b, pb_a};
        sync2_d = sync1_q;
        prev_d  = lvl_q;
        lvl_d   = '0;
        for (int i = 0; i < 3; i++) begin
            dbc_d[i] = '0;
            if (sync2_q[i]) begin
                dbc_d[i] = (dbc_q[i] == DB_MAX) ? DB_MAX : dbc_q[i] + 1'b1;
                lvl_d[i] = (dbc_d[i] == DB_MAX);
            end
        end
        press = lvl_q & ~prev_q;
    end

    logic [WIDTH:0] add_sum, sub_diff;
    logic [RW-1:0]  alu_res;
    logic [4:0]     alu_flags;

    always_comb begin
        add_sum   = {1'b0, a_q} + {1'b0, b_q};
        sub_diff  = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = '0;
        alu_flags = '0;
        case (sw[3:0])
            OP_ADD: begin
                alu_res      = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                alu_flags[1] = add_sum[WIDTH];
                alu_flags[2] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res      = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                alu_flags[1] = sub_diff[WIDTH];
                alu_flags[2] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a_q};
            OP_SHL:  alu_res = {{WIDTH{1'b0}}, a_q << 1};
            OP_SHR:  alu_res = {{WIDTH{1'b0}}, a_q >> 1};
            default: alu_flags[4] = 1'b1;
        endcase
        alu_flags[0] = (alu_res == '0);
    end

    // One iteration of shift-add multiply and restoring divide on the work registers
    logic [RW-1:0]    mul_acc_n, fin;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;

    always_comb begin
        mul_acc_n = work_c_q[0] ? work_a_q + work_b_q : work_a_q;
        div_shift = {work_a_q[WIDTH-1:0], work_c_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        if (!div_trial[WIDTH]) begin
            div_rem_n = div_trial[WIDTH-1:0];
            div_quo_n = {work_c_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_n = div_shift[WIDTH-1:0];
            div_quo_n = {work_c_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        led_d    = led_q;
        result_d = result_q;
        flags_d  = flags_q;
        op_d     = op_q;
        work_a_d = work_a_q;
        work_b_d = work_b_q;
        work_c_d = work_c_q;
        step_d   = step_q;
        fin      = '0;
        case (state_q)
            IDLE: begin
                if (press[0]) begin
                    a_d   = sw;
                    led_d = sw;
                end else if (press[1]) begin
                    b_d   = sw;
                    led_d = sw;
                end else if (press[2]) begin
                    op_d = sw[3:0];
                    if (sw[3:0] == OP_MUL) begin
                        work_a_d = '0;
                        work_b_d = {{WIDTH{1'b0}}, a_q};
                        work_c_d = b_q;
                        step_d   = '0;
                        state_d  = EXEC;
                    end else if (sw[3:0] == OP_DIV && b_q != '0) begin
                        work_a_d = '0;
                        work_c_d = a_q;
                        step_d   = '0;
                        state_d  = EXEC;
                    end else if (sw[3:0] == OP_DIV) begin
                        result_d = {a_q, {WIDTH{1'b1}}};
                        flags_d  = 5'b01000;
                        led_d    = '1;
                        state_d  = DONE;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        led_d    = alu_res[WIDTH-1:0];
                        state_d  = DONE;
                    end
                end
            end
            EXEC: begin
                step_d = step_q + 1'b1;
                if (op_q == OP_MUL) begin
                    work_a_d = mul_acc_n;
                    work_b_d = work_b_q << 1;
                    work_c_d = work_c_q >> 1;
                    fin      = mul_acc_n;
                end else begin
                    work_a_d = {{WIDTH{1'b0}}, div_rem_n};
                    work_c_d = div_quo_n;
                    fin      = {div_rem_n, div_quo_n};
                end
                if (step_q == ST_LAST) begin
                    result_d = fin;
                    flags_d  = {4'b0000, fin == '0};
                    led_d    = fin[WIDTH-1:0];
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [4*DIGITS-1:0] disp;
    logic [3:0]          nibble;

    always_comb begin
        rf_cnt_d = rf_cnt_q + 1'b1;
        digit_d  = digit_q;
        if (rf_cnt_q == RF_LAST) begin
            rf_cnt_d = '0;
            digit_d  = (digit_q == DG_LAST) ? '0 : digit_q + 1'b1;
        end
        disp = '0;
        for (int i = 0; i < 4 * DIGITS; i++) begin
            if (i < RW) disp[i] = result_q[i];
        end
        nibble = '0;
        AN_SEL = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DGW'(i)) begin
                nibble    = disp[i*4 +: 4];
                AN_SEL[i] = 1'b0;
            end
        end
        case (nibble)
            4'h0: seven_seg_out = 7'b1000000;
            4'h1: seven_seg_out = 7'b1111001;
            4'h2: seven_seg_out = 7'b0100100;
            4'h3: seven_seg_out = 7'b0110000;
            4'h4: seven_seg_out = 7'b0011001;
            4'h5: seven_seg_out = 7'b0010010;
            4'h6: seven_seg_out = 7'b0000010;
            4'h7: seven_seg_out = 7'b1111000;
            4'h8: seven_seg_out = 7'b0000000;
            4'h9: seven_seg_out = 7'b0010000;
            4'hA: seven_seg_out = 7'b0001000;
            4'hB: seven_seg_out = 7'b0000011;
            4'hC: seven_seg_out = 7'b1000110;
            4'hD: seven_seg_out = 7'b0100001;
            4'hE: seven_seg_out = 7'b0000110;
            default: seven_seg_out = 7'b0001110;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            prev_q   <= '0;
            for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            led_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            op_q     <= '0;
            work_a_q <= '0;
            work_b_q <= '0;
            work_c_q <= '0;
            step_q   <= '0;
            rf_cnt_q <= '0;
            digit_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            lvl_q    <= lvl_d;
            prev_q   <= prev_d;
            for (int i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            led_q    <= led_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
            work_a_q <= work_a_d;
            work_b_q <= work_b_d;
            work_c_q <= work_c_d;
            step_q   <= step_d;
            rf_cnt_q <= rf_cnt_d;
            digit_q  <= digit_d;
        end
    end

    assign LED          = led_q;
    assign flags        = flags_q;
    assign busy         = (state_q == EXEC);
    assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_param_alu_top.sv
// Directed bench for param_alu_top with short debounce/refresh so each button press takes a few clocks.
module tb_param_alu_top;

    logic       Clk = 1'b0;
    logic       reset, pb_a, pb_b, pb_op;
    logic [7:0] sw;
    logic [7:0] LED;
    logic [3:0] AN_SEL;
    logic [6:0] seven_seg_out;
    logic       busy, result_valid;
    logic [4:0] flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    param_alu_top #(.WIDTH(8), .DIGITS(4), .DEBOUNCE_CYC(4), .REFRESH_DIV(4)) dut (
        .Clk(Clk), .reset(reset), .pb_a(pb_a), .pb_b(pb_b), .pb_op(pb_op), .sw(sw),
        .LED(LED), .AN_SEL(AN_SEL), .seven_seg_out(seven_seg_out), .busy(busy),
        .result_valid(result_valid), .flags(flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] seg2nib(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h00;  7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;  7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;  7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;  7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;  7'b0010000: return 5'h09;
            7'b0001000: return 5'h0A;  7'b0000011: return 5'h0B;
            7'b1000110: return 5'h0C;  7'b0100001: return 5'h0D;
            7'b0000110: return 5'h0E;  7'b0001110: return 5'h0F;
            default:    return 5'h10;
        endcase
    endfunction

    // Scan one full refresh cycle and rebuild the 16-bit value shown on the digits
    task automatic check_disp(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        logic [4:0]  nb;
        logic [3:0]  sel;
        v = 'x;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 4; d++) begin
                sel = 4'b1111 ^ (4'b0001 << d);
                if (AN_SEL == sel) begin
                    nb = seg2nib(seven_seg_out);
                    if (!nb[4]) v[d*4 +: 4] = nb[3:0];
                end
            end
        end
        check(tag, {16'h0, v}, {16'h0, exp});
    endtask

    task automatic load(input string tag, input bit is_b, input logic [7:0] val);
        sw = val;
        if (is_b) pb_b = 1'b1; else pb_a = 1'b1;
        repeat (10) @(negedge Clk);
        pb_a = 1'b0;
        pb_b = 1'b0;
        repeat (4) @(negedge Clk);
        check(tag, {24'h0, LED}, {24'h0, val});
    endtask

    task automatic run_op(input string tag, input logic [3:0] opc, input bit inject, input int exp_busy,
                          input logic [7:0] exp_led, input logic [4:0] exp_flags, input logic [15:0] exp_disp);
        int nvalid, nbusy, vidx, lbidx;
        logic [7:0] led_v;
        logic [4:0] flg_v;
        nvalid = 0; nbusy = 0; vidx = -1; lbidx = -1; led_v = 'x; flg_v = 'x;
        sw    = {4'h0, opc};
        pb_op = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (busy) begin
                nbusy++;
                lbidx = k;
                if (inject && nbusy == 1) begin
                    sw   = 8'h12;
                    pb_a = 1'b1;
                end
            end
            if (result_valid) begin
                nvalid++;
                vidx  = k;
                led_v = LED;
                flg_v = flags;
            end
        end
        pb_op = 1'b0;
        pb_a  = 1'b0;
        repeat (4) @(negedge Clk);
        check({tag, "/valid_cnt"}, nvalid, 1);
        check({tag, "/busy_cnt"}, nbusy, exp_busy);
        if (exp_busy > 0) check({tag, "/valid_after_busy"}, vidx, lbidx + 1);
        check({tag, "/led"}, {24'h0, led_v}, {24'h0, exp_led});
        check({tag, "/flags"}, {27'h0, flg_v}, {27'h0, exp_flags});
        check_disp({tag, "/disp"}, exp_disp);
    endtask

    initial begin
        int nv;
        bit found;
        logic [3:0] exp_an;
        reset = 1'b1; pb_a = 1'b0; pb_b = 1'b0; pb_op = 1'b0; sw = 8'h00;
        repeat (3) @(negedge Clk);
        check("rst/led", {24'h0, LED}, 32'h00);
        check("rst/busy", {31'h0, busy}, 32'h0);
        check("rst/valid", {31'h0, result_valid}, 32'h0);
        check("rst/flags", {27'h0, flags}, 32'h0);
        check("rst/an_sel", {28'h0, AN_SEL}, 32'hE);
        check("rst/seg", {25'h0, seven_seg_out}, 32'h40);

        // Digit scan starts on digit 0 and advances every 4 clocks
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge Clk);
            exp_an = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
            check($sformatf("scan/an_sel[%0d]", k), {28'h0, AN_SEL}, {28'h0, exp_an});
        end

        load("load_a_0f", 1'b0, 8'h0F);
        load("load_b_05", 1'b1, 8'h05);
        run_op("add_0f_05", 4'd0, 1'b0, 0, 8'h14, 5'b00000, 16'h0014);
        load("load_a_7f", 1'b0, 8'h7F);
        load("load_b_01", 1'b1, 8'h01);
        run_op("add_ovf", 4'd0, 1'b0, 0, 8'h80, 5'b00100, 16'h0080);

        load("load_a_ff", 1'b0, 8'hFF);
        load("load_b_ff", 1'b1, 8'hFF);
        run_op("mul_ff_ff", 4'd8, 1'b1, 8, 8'h01, 5'b00000, 16'hFE01);
        run_op("add_ff_ff", 4'd0, 1'b0, 0, 8'hFE, 5'b00010, 16'h00FE);

        load("load_a_64", 1'b0, 8'h64);
        load("load_b_07", 1'b1, 8'h07);
        run_op("div_64_07", 4'd9, 1'b0, 8, 8'h0E, 5'b00000, 16'h020E);
        load("load_b_00", 1'b1, 8'h00);
        run_op("div_by_0", 4'd9, 1'b0, 0, 8'hFF, 5'b01000, 16'h64FF);

        // A 3-clock glitch on pb_a must not load
        sw = 8'h55;
        pb_a = 1'b1;
        repeat (3) @(negedge Clk);
        pb_a = 1'b0;
        repeat (10) @(negedge Clk);
        check("short_press/led", {24'h0, LED}, 32'hFF);
        run_op("illegal_12", 4'd12, 1'b0, 0, 8'h00, 5'b10001, 16'h0000);
        run_op("add_64_00", 4'd0, 1'b0, 0, 8'h64, 5'b00000, 16'h0064);

        // pb_a and pb_op together: only the load happens
        sw = 8'h33;
        pb_a = 1'b1;
        pb_op = 1'b1;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (result_valid) nv++;
        end
        pb_a = 1'b0;
        pb_op = 1'b0;
        repeat (4) @(negedge Clk);
        check("simul/valid_cnt", nv, 0);
        check("simul/led", {24'h0, LED}, 32'h33);
        run_op("add_33_00", 4'd0, 1'b0, 0, 8'h33, 5'b00000, 16'h0033);

        // Reset during the 4th EXEC clock of a MUL
        sw = 8'h08;
        pb_op = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (busy) begin
                found = 1'b1;
                break;
            end
        end
        check("abort/busy_seen", {31'h0, found}, 32'h1);
        repeat (3) @(negedge Clk);
        reset = 1'b1;
        pb_op = 1'b0;
        @(negedge Clk);
        reset = 1'b0;
        check("abort/busy", {31'h0, busy}, 32'h0);
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (result_valid) nv++;
        end
        check("abort/valid_cnt", nv, 0);
        check("abort/led", {24'h0, LED}, 32'h00);
        check("abort/flags", {27'h0, flags}, 32'h0);
        check_disp("abort/disp", 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_alu_top.md
PARAM_ALU_TOP -- requirements
Module: param_alu_top

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits (4..16).
REQ-002 Parameter: DIGITS, 4, number of seven-segment digits; the display shows the low 4*DIGITS result bits.
REQ-003 Parameter: DEBOUNCE_CYC, 250000, consecutive stable-high clocks before a push-button counts as pressed.
REQ-004 Parameter: REFRESH_DIV, 50000, clocks each digit stays lit.
REQ-005 Port: Clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: pb_a / pb_b / pb_op  input  1 each  raw push-buttons: load A, load B, execute.
REQ-008 Port: sw  input  WIDTH  operand value on pb_a/pb_b; opcode in sw[3:0] on pb_op.
REQ-009 Port: LED  output  WIDTH  display value, registered.
REQ-010 Port: AN_SEL  output  DIGITS  digit enable, active-low, one-hot-low.
REQ-011 Port: seven_seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low, hex glyphs 0-F.
REQ-012 Port: busy  output  1  high while a multi-cycle op is in progress.
REQ-013 Port: result_valid  output  1  one-cycle pulse when the result register updates.
REQ-014 Port: flags  output  5  {illegal, div0, overflow, carry, zero}, registered with the result.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser and a debouncer; the debounced level rises after DEBOUNCE_CYC stable-high clocks and falls on the first low sample; its rising edge produces a one-cycle press pulse.
REQ-016 FSM states SHALL be IDLE, EXEC, DONE; press pulses are acted on only in IDLE.
REQ-017 Same-cycle presses SHALL be resolved by priority pb_a > pb_b > pb_op; lower-priority presses are discarded.
REQ-018 A press in IDLE SHALL load A=sw (or B=sw) on the next edge and set LED to that operand.
REQ-019 Opcodes SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A<<1, 7 A>>1 (logical), 8 MUL, 9 DIV; 10-15 are illegal.
REQ-020 The result register SHALL be 2*WIDTH wide; ops 0-7 zero-extend to it; MUL = full product; DIV = {remainder, quotient}.
REQ-021 Ops 0-7 and illegal opcodes SHALL complete in the edge after the press (IDLE->DONE); illegal gives result 0 and illegal=1.
REQ-022 MUL (shift-add) and DIV (restoring) SHALL enter EXEC with busy=1 for exactly WIDTH clocks, then go to DONE; result_valid is high WIDTH+1 clocks after the press.
REQ-023 DIV with B=0 SHALL complete like a single-cycle op: quotient all-ones, remainder A, div0=1.
REQ-024 Flags: zero = (result==0); carry = ADD carry-out or SUB borrow; overflow = signed overflow of ADD/SUB; all flags are 0 for other ops except as stated.
REQ-025 DONE SHALL last one cycle with result_valid=1 and LED=result[WIDTH-1:0], then return to IDLE.
REQ-026 Presses arriving in EXEC or DONE SHALL be discarded, not queued; sw changes during EXEC do not affect the op.
REQ-027 A digit counter SHALL advance every REFRESH_DIV clocks and wrap from DIGITS-1 to 0; digit i shows result nibble i.

Reset
REQ-028 While reset is high: A, B, result, flags, LED = 0; busy = 0; result_valid = 0; FSM = IDLE; debouncers cleared; digit counter 0; AN_SEL = all ones except bit0 low; seven_seg_out = 7'b1000000.
REQ-029 Reset asserted mid-EXEC SHALL abort the op; there is no result_valid pulse, and busy = 0 after the next edge.

Verification (WIDTH=8, DIGITS=4, DEBOUNCE_CYC=4, REFRESH_DIV=4)
REQ-030 Reset for 3 clocks -> LED=0x00, busy=0, AN_SEL=4'b1110, seven_seg_out=7'b1000000.
REQ-031 Load A=0x0F, B=0x05, op 0 -> result=0x0014, LED=0x14, flags=0, result_valid one clock after the op press; 0x7F+0x01 -> 0x0080, overflow=1, carry=0.
REQ-032 A=0xFF, B=0xFF, op 8 -> busy for 8 clocks, result=0xFE01 at press+9; a pb_a press during busy leaves A=0xFF.
REQ-033 A=0x64, B=0x07, op 9 -> result=0x020E; B=0x00 -> result=0x64FF, div0=1, after 1 clock.
REQ-034 pb_a high for only 3 clocks -> no load; op 12 -> result=0, illegal=1; pb_a+pb_op in the same cycle -> only A loads.
REQ-035 Reset at the 4th EXEC clock of a MUL -> no result_valid, result=0, busy=0; AN_SEL cycles 1110, 1101, 1011, 0111, 1110 every 4 clocks.
